// File: rtl/ulpi_rx_parser.sv
// Passive ULPI receive snooper: separates RX CMDs from packet bytes, frames each
// packet with sop/eop/err and buffers the bytes in a small FIFO with registered outputs.
module ulpi_rx_parser #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk_ext,
  input  logic       rst,
  input  logic       DIR,
  input  logic       NXT,
  input  logic [7:0] ULPI_DATA_IN,
  input  logic       rx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_sop,
  output logic       rx_eop,
  output logic       rx_err,
  output logic [1:0] line_state,
  output logic [1:0] vbus_state,
  output logic       rx_active,
  output logic [7:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, TURN, LISTEN, PKT} state_t;

  state_t      state, state_nxt;
  logic        d_q, n_q;
  logic [7:0]  b_q;
  logic        cmd_upd, pkt_start, data_byte, pkt_end, end_err, set_err;
  logic        err_flag, pend_valid, pend_first, discard;
  logic [7:0]  pend_data;
  logic [AW:0] wr_ptr, rd_ptr, rd_nxt;
  logic [10:0] mem [DEPTH];
  logic [10:0] push_entry;
  logic        full, pop, push_req, push_ok, overflow, head_avail;

  always_ff @(posedge clk_ext or negedge rst) begin
    if (!rst) begin
      d_q <= 1'b0;
      n_q <= 1'b0;
      b_q <= 8'h00;
    end else begin
      d_q <= DIR;
      n_q <= NXT;
      b_q <= ULPI_DATA_IN;
    end
  end

  always_ff @(posedge clk_ext or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Both bus turnarounds cost one ignored cycle; a DIR drop inside a packet aborts it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (d_q) state_nxt = TURN;
      TURN:    state_nxt = LISTEN;
      LISTEN:  if (!d_q) state_nxt = IDLE;
               else if (!n_q && b_q[4]) state_nxt = PKT;
      PKT:     if (!d_q) state_nxt = TURN;
               else if (!n_q && !b_q[4]) state_nxt = LISTEN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_upd   = 1'b0;
    pkt_start = 1'b0;
    data_byte = 1'b0;
    pkt_end   = 1'b0;
    set_err   = 1'b0;
    end_err   = ~d_q | err_flag;
    case (state)
      LISTEN: if (d_q && !n_q) begin
        cmd_upd   = 1'b1;
        pkt_start = b_q[4];
      end
      PKT: if (!d_q) begin
        pkt_end = 1'b1;
      end else if (n_q) begin
        data_byte = 1'b1;
      end else begin
        cmd_upd = 1'b1;
        set_err = (b_q[5:4] == 2'b11);
        pkt_end = ~b_q[4];
      end
      default: ;
    endcase
  end

  // The pending byte is released by the next data byte or, tagged eop, by the packet end.
  always_comb begin
    pop        = rx_ready & rx_valid;
    full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    push_req   = pend_valid & (data_byte | pkt_end);
    push_entry = {pkt_end & end_err, pkt_end, pend_first, pend_data};
    push_ok    = push_req & ~discard & (~full | pop);
    overflow   = push_req & ~discard & full & ~pop;
    rd_nxt     = pop ? rd_ptr + {{AW{1'b0}}, 1'b1} : rd_ptr;
    head_avail = (wr_ptr != rd_nxt);
  end

  always_ff @(posedge clk_ext or negedge rst) begin
    if (!rst) begin
      line_state <= 2'b00;
      vbus_state <= 2'b00;
      rx_active  <= 1'b0;
      err_flag   <= 1'b0;
      pend_valid <= 1'b0;
      pend_first <= 1'b0;
      pend_data  <= 8'h00;
      discard    <= 1'b0;
      drop_cnt   <= 8'h00;
    end else begin
      if (cmd_upd) begin
        line_state <= b_q[1:0];
        vbus_state <= b_q[3:2];
      end
      if (pkt_start) begin
        rx_active  <= 1'b1;
        err_flag   <= 1'b0;
        discard    <= 1'b0;
        pend_valid <= 1'b0;
      end
      if (set_err) err_flag <= 1'b1;
      if (data_byte) begin
        pend_data  <= b_q;
        pend_first <= ~pend_valid;
        pend_valid <= 1'b1;
      end
      if (pkt_end) begin
        rx_active  <= 1'b0;
        pend_valid <= 1'b0;
      end
      if (overflow) begin
        discard <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_ext) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  // The head register reads at the post-pop pointer, so a just-written entry shows a cycle later.
  always_ff @(posedge clk_ext or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
      rx_sop   <= 1'b0;
      rx_eop   <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      rd_ptr   <= rd_nxt;
      rx_valid <= head_avail;
      {rx_err, rx_eop, rx_sop, rx_data} <= head_avail ? mem[rd_nxt[AW-1:0]] : 11'h000;
    end
  end

endmodule

// File: tb/tb_ulpi_rx_parser.sv
// Directed bench for ulpi_rx_parser: drives ULPI receive sequences and checks popped
// FIFO entries against a queue of expected {err, eop, sop, data} words.
module tb_ulpi_rx_parser;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic       clk_ext = 1'b0;
  logic       rst;
  logic       DIR, NXT, rx_ready;
  logic [7:0] ULPI_DATA_IN;
  logic       rx_valid, rx_sop, rx_eop, rx_err, rx_active;
  logic [7:0] rx_data, drop_cnt;
  logic [1:0] line_state, vbus_state;

  int          total_cnt  = 0;
  int          passed_cnt = 0;
  int          failed_cnt = 0;
  logic [10:0] exp_q[$];

  ulpi_rx_parser #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_ext(clk_ext), .rst(rst), .DIR(DIR), .NXT(NXT), .ULPI_DATA_IN(ULPI_DATA_IN),
    .rx_ready(rx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_sop(rx_sop),
    .rx_eop(rx_eop), .rx_err(rx_err), .line_state(line_state), .vbus_state(vbus_state),
    .rx_active(rx_active), .drop_cnt(drop_cnt)
  );

  always #8 clk_ext = ~clk_ext;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) passed_cnt++;
    else begin
      failed_cnt++;
      $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are set just after a rising edge and sampled by the DUT on the next one.
  task automatic applyStimulus(input logic dir, input logic nxt, input logic [7:0] data);
    DIR = dir;
    NXT = nxt;
    ULPI_DATA_IN = data;
    @(posedge clk_ext);
    #1;
  endtask

  task automatic send_start(input logic [7:0] cmd);
    repeat (3) applyStimulus(1'b1, 1'b0, cmd);
  endtask

  task automatic bus_release();
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic expect_entry(input logic err, input logic eop, input logic sop, input logic [7:0] d);
    exp_q.push_back({err, eop, sop, d});
  endtask

  task automatic send_packet(input logic [7:0] start_cmd, input int n, input logic [7:0] base,
                             input logic [7:0] end_cmd);
    send_start(start_cmd);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, base + 8'(i));
    applyStimulus(1'b1, 1'b0, end_cmd);
    bus_release();
  endtask

  task automatic wait_drain(input string tag);
    rx_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk_ext);
    repeat (4) @(posedge clk_ext);
    #1;
    checkOutput({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    checkOutput({tag, "_empty"}, 32'(rx_valid), 32'd0);
  endtask

  always @(negedge clk_ext) begin
    if (rst && rx_valid && rx_ready) begin
      total_cnt++;
      assert (exp_q.size() != 0) passed_cnt++;
      else begin
        failed_cnt++;
        $error("[TB] FAIL unexpected_pop: got 0x%0h expected no entry", {rx_err, rx_eop, rx_sop, rx_data});
      end
      if (exp_q.size() != 0)
        checkOutput("pop", {21'd0, rx_err, rx_eop, rx_sop, rx_data}, {21'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    DIR = 1'b0;
    NXT = 1'b0;
    ULPI_DATA_IN = 8'h00;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk_ext);
    #1;
    checkOutput("reset_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset_drop", 32'(drop_cnt), 32'd0);
    checkOutput("reset_line", 32'(line_state), 32'd0);
    checkOutput("reset_active", 32'(rx_active), 32'd0);
    rst = 1'b1;
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);

    $display("[TB] normal packet");
    rx_ready = 1'b1;
    expect_entry(1'b0, 1'b0, 1'b1, 8'hC3);
    expect_entry(1'b0, 1'b0, 1'b0, 8'h80);
    expect_entry(1'b0, 1'b1, 1'b0, 8'h06);
    send_start(8'h11);
    applyStimulus(1'b1, 1'b1, 8'hC3);
    applyStimulus(1'b1, 1'b1, 8'h80);
    checkOutput("active_mid", 32'(rx_active), 32'd1);
    checkOutput("line_mid", 32'(line_state), 32'd1);
    applyStimulus(1'b1, 1'b1, 8'h06);
    applyStimulus(1'b1, 1'b0, 8'h01);
    bus_release();
    checkOutput("active_end", 32'(rx_active), 32'd0);
    checkOutput("line_end", 32'(line_state), 32'd1);
    wait_drain("normal");

    $display("[TB] abort");
    expect_entry(1'b0, 1'b0, 1'b1, 8'hC3);
    expect_entry(1'b1, 1'b1, 1'b0, 8'h80);
    send_start(8'h11);
    applyStimulus(1'b1, 1'b1, 8'hC3);
    applyStimulus(1'b1, 1'b1, 8'h80);
    bus_release();
    checkOutput("abort_active", 32'(rx_active), 32'd0);
    wait_drain("abort");

    $display("[TB] rx error, zero-byte and single-byte packets");
    expect_entry(1'b0, 1'b0, 1'b1, 8'hAA);
    expect_entry(1'b1, 1'b1, 1'b0, 8'h55);
    send_start(8'h11);
    applyStimulus(1'b1, 1'b1, 8'hAA);
    applyStimulus(1'b1, 1'b0, 8'h31);
    applyStimulus(1'b1, 1'b1, 8'h55);
    applyStimulus(1'b1, 1'b0, 8'h01);
    bus_release();
    wait_drain("rxerr");
    send_packet(8'h11, 0, 8'h00, 8'h01);
    wait_drain("zero");
    expect_entry(1'b0, 1'b1, 1'b1, 8'h5A);
    send_packet(8'h11, 1, 8'h5A, 8'h01);
    wait_drain("single");
    expect_entry(1'b0, 1'b1, 1'b1, 8'h7E);
    send_packet(8'h1E, 1, 8'h7E, 8'h2E);
    checkOutput("line_10", 32'(line_state), 32'd2);
    checkOutput("vbus_11", 32'(vbus_state), 32'd3);
    wait_drain("vbus");

    $display("[TB] push and pop together while full");
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) expect_entry(1'b0, i == 5, i == 1, 8'(i));
    send_start(8'h11);
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b1, 8'(i));
    applyStimulus(1'b1, 1'b0, 8'h01);
    rx_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h01);
    rx_ready = 1'b0;
    bus_release();
    checkOutput("simul_drop", 32'(drop_cnt), 32'd0);
    checkOutput("simul_hold", 32'(rx_valid), 32'd1);
    wait_drain("simul");

    $display("[TB] overflow");
    rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) expect_entry(1'b0, 1'b0, i == 0, 8'hA0 + 8'(i));
    send_packet(8'h11, 10, 8'hA0, 8'h01);
    checkOutput("ovf_drop", 32'(drop_cnt), 32'd1);
    checkOutput("ovf_hold", 32'(rx_valid), 32'd1);
    wait_drain("ovf");
    for (int i = 0; i < 3; i++) expect_entry(1'b0, i == 2, i == 0, 8'hB0 + 8'(i));
    send_packet(8'h11, 3, 8'hB0, 8'h01);
    wait_drain("after_ovf");

    $display("[TB] drop counter saturation");
    rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) expect_entry(1'b0, 1'b0, i == 0, 8'h40 + 8'(i));
    for (int p = 0; p < 300; p++) begin
      send_packet(8'h11, 6, 8'h40, 8'h01);
      if (p == 252) checkOutput("drop_254", 32'(drop_cnt), 32'd254);
    end
    checkOutput("drop_sat", 32'(drop_cnt), 32'd255);
    wait_drain("sat");

    $display("[TB] reset mid-packet");
    rx_ready = 1'b0;
    send_start(8'h11);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 8'hD0 + 8'(i));
    applyStimulus(1'b1, 1'b0, 8'h11);
    checkOutput("pre_rst_valid", 32'(rx_valid), 32'd1);
    checkOutput("pre_rst_active", 32'(rx_active), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(rx_valid), 32'd0);
    checkOutput("rst_drop", 32'(drop_cnt), 32'd0);
    checkOutput("rst_active", 32'(rx_active), 32'd0);
    checkOutput("rst_line", 32'(line_state), 32'd0);
    exp_q.delete();
    DIR = 1'b0;
    NXT = 1'b0;
    ULPI_DATA_IN = 8'h00;
    repeat (2) @(posedge clk_ext);
    #1;
    rst = 1'b1;
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
    rx_ready = 1'b1;
    expect_entry(1'b0, 1'b0, 1'b1, 8'hC3);
    expect_entry(1'b0, 1'b0, 1'b0, 8'h80);
    expect_entry(1'b0, 1'b1, 1'b0, 8'h06);
    send_start(8'h11);
    applyStimulus(1'b1, 1'b1, 8'hC3);
    applyStimulus(1'b1, 1'b1, 8'h80);
    applyStimulus(1'b1, 1'b1, 8'h06);
    applyStimulus(1'b1, 1'b0, 8'h01);
    bus_release();
    wait_drain("post_rst");

    $display("%0d/%0d checks passed", passed_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ulpi_rx_parser.md
Name: ulpi_rx_parser

Overview:
- Passive receive-side stage that snoops the USB3300 ULPI bus.
- Separates RX CMD bytes from USB packet data bytes.
- Frames each received packet with start and end markers.
- Buffers packet bytes in a small FIFO for the downstream capture and transmit logic.
- Tracks PHY line state, VBUS state and receive status from the RX CMDs.

Parameters:
- DEPTH, 16, FIFO depth in entries; power of two, 4 to 256.
- AW, 4, FIFO address width; must equal log2(DEPTH).

Ports:
- clk_ext  in  1  60 MHz ULPI clock from the PHY; all logic runs on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- DIR  in  1  ULPI direction (PHY drives the bus when high).
- NXT  in  1  ULPI next.
- ULPI_DATA_IN  in  8  ULPI data bus as sampled at the pad input.
- rx_ready  in  1  downstream pops the FIFO head when rx_ready && rx_valid.
- rx_valid  out  1  FIFO is not empty.
- rx_data  out  8  data byte at the FIFO head.
- rx_sop  out  1  head byte is the first byte of a packet.
- rx_eop  out  1  head byte is the last byte of a packet.
- rx_err  out  1  packet ended abnormally; qualified by rx_eop.
- line_state  out  2  RX CMD bits [1:0].
- vbus_state  out  2  RX CMD bits [3:2].
- rx_active  out  1  a packet is in progress.
- drop_cnt  out  8  number of packets truncated by FIFO overflow; saturates at 255.

Behaviour:
- Reset (rst low) clears every output and all state immediately: FIFO empty, rx_valid=0, rx_data/sop/eop/err=0, line_state=0, vbus_state=0, rx_active=0, drop_cnt=0, FSM=IDLE.
- Input stage: DIR, NXT and ULPI_DATA_IN are registered once (d_q, n_q, b_q). All decoding below uses these registered values.
- FSM states and transitions:
  - IDLE: d_q=0. A 0->1 transition of d_q moves to TURN.
  - TURN: one cycle only. The bus byte is ignored (turnaround). Next state is LISTEN.
  - LISTEN: d_q=1 and n_q=0, so b_q is an RX CMD. Update line_state=b_q[1:0] and vbus_state=b_q[3:2]. If b_q[5:4] is 01 or 11, set rx_active=1 and go to PKT. A d_q=0 cycle returns to IDLE.
  - PKT:
    - n_q=1: b_q is a data byte.
    - n_q=0: b_q is an RX CMD. Update line_state and vbus_state. If b_q[5:4]=11, set the packet error flag. If b_q[5:4]=00 or 10, end the packet normally (error flag kept if set); rx_active=0; go to LISTEN.
    - d_q falls while in PKT: end the packet with err=1; rx_active=0; go to TURN. Turnaround also applies 1->0.
- Holding register: a packet's last byte is only known when the packet ends, so each data byte is held in a one-entry pending register.
  - When the next data byte arrives, the pending byte is written to the FIFO with sop=1 if it was the first byte of the packet, eop=0.
  - At packet end, the pending byte is written with eop=1 and err=error flag.
  - A packet with zero data bytes writes nothing.
  - A single-byte packet writes one entry with sop=1 and eop=1.
- Latency: a byte at the pad on edge k reaches the pending register at edge k+2. It reaches the FIFO one cycle after the event that releases it. rx_valid rises on the following edge, because the output is registered from the FIFO.
- FIFO:
  - Entries are 11 bits: {err, eop, sop, data}.
  - A simultaneous push and pop is allowed when full: the pop frees the slot first.
  - Pointers are AW+1 bits; full and empty are derived from the MSB compare; wrap-around is natural.
- Overflow:
  - A write while full (with no simultaneous pop) is dropped.
  - The rest of that packet is discarded.
  - drop_cnt increments once for the packet, saturating at 255.
  - The truncated packet never receives an eop. Downstream treats a new rx_sop as implicitly terminating the prior packet with error.
- PKT is only entered from LISTEN. A data byte (n_q=1) seen in LISTEN is ignored.

Test Plan:
- Reset mid-packet: assert rst low during PKT with 3 bytes buffered -> rx_valid=0, drop_cnt=0, FSM=IDLE immediately. After release, the next packet frames cleanly.
- Normal packet: DIR up, turnaround, RX CMD 0x11, data 0xC3 0x80 0x06, RX CMD 0x01 -> FIFO holds C3(sop), 80, 06(eop, err=0); line_state=01 throughout.
- Abort: same packet but DIR falls after 0x80 -> C3(sop), 80(eop, err=1); rx_active=0.
- RxError: RX CMD 0x31 mid-packet, then 0x01 -> last byte has eop=1, err=1. Zero-byte packet (0x11 then 0x01) -> FIFO stays empty.
- Overflow: DEPTH=4, rx_ready=0, 10-byte packet -> 4 entries with no eop, drop_cnt=1. Next packet after draining is intact. 300 such packets -> drop_cnt=255.
- Simultaneous: FIFO full, rx_ready=1 on the same cycle as a push -> no drop, occupancy unchanged.
